// File: rtl/ah_xfer_pkg.sv
// Shared types and helpers for the grant-to-FIFO transfer stage.
// Holds the requester geometry, the FIFO entry layout and the grant decode functions.
package ah_xfer_pkg;

    localparam int unsigned N   = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned IDW = 5;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
    } entry_t;

    localparam int unsigned EW = IDW + DW;
    localparam entry_t ENTRY_ZERO = '0;

    // OR-reduction encoder; only meaningful when the input is one-hot.
    function automatic logic [IDW-1:0] onehot_to_bin(input logic [N-1:0] oh);
        logic [IDW-1:0] bin;
        bin = '0;
        for (int i = 0; i < N; i++) begin
            if (oh[i]) begin
                bin = bin | IDW'(i);
            end
        end
        return bin;
    endfunction

    function automatic logic is_onehot(input logic [N-1:0] v);
        return (v != '0) && ((v & (v - N'(1))) == '0);
    endfunction

endpackage

// File: rtl/ah_sync_fifo.sv
// Synchronous first-word fall-through FIFO with occupancy count.
// The head word reads as zero while the FIFO is empty.
module ah_sync_fifo #(
    parameter int unsigned WIDTH = 37,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot the push will use.
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = empty ? '0 : mem[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/ah_grant_xfer_32.sv
// Captures the arbiter's one-hot grant winner into a FWFT FIFO, acks the winner,
// counts grants dropped for lack of space and flags malformed grants.
module ah_grant_xfer_32
    import ah_xfer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N-1:0]             gnt,
    input  logic [N*DW-1:0]          req_data,
    output logic [N-1:0]             req_ack,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_data,
    output logic [IDW-1:0]           out_id,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic [CW-1:0]            drop_cnt,
    output logic                     gnt_err
);

    logic           gnt_valid, gnt_multi;
    logic [IDW-1:0] idx;
    entry_t         wr_entry, head;
    logic           full, empty, pop, push, drop;
    logic [N-1:0]   ack_q, ack_d;
    logic [CW-1:0]  drop_q, drop_d;
    logic           err_q, err_d;

    assign gnt_valid = is_onehot(gnt);
    assign gnt_multi = (gnt != '0) & ~gnt_valid;
    assign idx       = onehot_to_bin(gnt);

    always_comb begin
        wr_entry      = ENTRY_ZERO;
        wr_entry.id   = idx;
        wr_entry.data = req_data[idx*DW +: DW];
    end

    assign pop  = out_valid & out_ready;
    assign push = gnt_valid & (~full | pop);
    assign drop = gnt_valid & full & ~pop;

    always_comb begin
        ack_d  = push ? gnt : '0;
        drop_d = drop_q;
        if (drop && (drop_q != '1)) drop_d = drop_q + CW'(1);
        err_d  = err_q | gnt_multi;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q  <= '0;
            drop_q <= '0;
            err_q  <= 1'b0;
        end else begin
            ack_q  <= ack_d;
            drop_q <= drop_d;
            err_q  <= err_d;
        end
    end

    ah_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_cnt)
    );

    assign out_valid = ~empty;
    assign out_data  = head.data;
    assign out_id    = head.id;
    assign req_ack   = ack_q;
    assign drop_cnt  = drop_q;
    assign gnt_err   = err_q;

endmodule
